// File: rtl/display_pkg.sv
// Shared display definitions: LCD timing defaults, pixel types and the 2-bit palette.
// Also used by the sprite painter and the frame RAM wrapper.
package display_pkg;

  localparam int COOR_WIDTH_DEF = 11;
  localparam int H_ACTIVE_DEF   = 800;
  localparam int H_FP_DEF       = 210;
  localparam int H_SYNC_DEF     = 20;
  localparam int H_BP_DEF       = 26;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 22;
  localparam int V_SYNC_DEF     = 10;
  localparam int V_BP_DEF       = 13;

  typedef logic [1:0]  palette_t;
  typedef logic [23:0] rgb_t;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  // Grey ramp from light (index 0) to black (index 3)
  localparam rgb_t PALETTE [4] = '{24'hF7F7F7, 24'hACACAC, 24'h535353, 24'h000000};

endpackage

// File: rtl/video_timing.sv
// Free-running h/v raster counters with active, sync, vblank and frame-end decode.
// All outputs are combinational from the counter registers (stage 0).
module video_timing
  import display_pkg::*;
#(
  parameter int COOR_WIDTH = COOR_WIDTH_DEF,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  output logic [COOR_WIDTH-1:0] o_h_cnt,
  output logic [COOR_WIDTH-1:0] o_v_cnt,
  output logic                  o_active,
  output logic                  o_hs_raw,
  output logic                  o_vs_raw,
  output logic                  o_vblank,
  output logic                  o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL >= (1 << COOR_WIDTH)) || (V_TOTAL >= (1 << COOR_WIDTH))) begin : g_bad_timing
    $fatal(1, "video_timing: H_TOTAL/V_TOTAL do not fit in COOR_WIDTH bits");
  end

  localparam logic [COOR_WIDTH-1:0] H_LAST = COOR_WIDTH'(H_TOTAL - 1);
  localparam logic [COOR_WIDTH-1:0] V_LAST = COOR_WIDTH'(V_TOTAL - 1);
  localparam logic [COOR_WIDTH-1:0] H_VIS  = COOR_WIDTH'(H_ACTIVE);
  localparam logic [COOR_WIDTH-1:0] V_VIS  = COOR_WIDTH'(V_ACTIVE);
  localparam logic [COOR_WIDTH-1:0] HS_BEG = COOR_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [COOR_WIDTH-1:0] HS_END = COOR_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COOR_WIDTH-1:0] VS_BEG = COOR_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [COOR_WIDTH-1:0] VS_END = COOR_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  logic [COOR_WIDTH-1:0] r_h_cnt;
  logic [COOR_WIDTH-1:0] r_v_cnt;
  logic                  w_h_last;
  logic                  w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + COOR_WIDTH'(1);
    end else begin
      r_h_cnt <= r_h_cnt + COOR_WIDTH'(1);
    end
  end

  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_active    = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign o_hs_raw    = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
  assign o_vs_raw    = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
  assign o_vblank    = (r_v_cnt >= V_VIS);
  assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/frame_scanout.sv
// Front-buffer scan-out: drives RAM read addresses, expands palette indices to RGB888
// through a 2-stage pipeline, and applies buffer swaps only at frame boundaries.
module frame_scanout
  import display_pkg::*;
#(
  parameter int COOR_WIDTH = COOR_WIDTH_DEF,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  output logic [COOR_WIDTH-1:0] read_x,
  output logic [COOR_WIDTH-1:0] read_y,
  output logic                  read_buf,
  input  logic [1:0]            read_palette,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  front_buf,
  output logic                  vblank,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [23:0]           rgb
);

  function automatic rgb_t pal_to_rgb(input palette_t idx, input logic vld);
    return vld ? PALETTE[idx] : '0;
  endfunction

  logic [COOR_WIDTH-1:0] w_h_cnt;
  logic [COOR_WIDTH-1:0] w_v_cnt;
  logic                  w_active;
  logic                  w_hs_raw;
  logic                  w_vs_raw;
  logic                  w_vblank;
  logic                  w_frame_end;

  video_timing #(
    .COOR_WIDTH (COOR_WIDTH),
    .H_ACTIVE   (H_ACTIVE),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACTIVE),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP)
  ) u_timing (
    .clk_33m     (clk_33m),
    .rst         (rst),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_active    (w_active),
    .o_hs_raw    (w_hs_raw),
    .o_vs_raw    (w_vs_raw),
    .o_vblank    (w_vblank),
    .o_frame_end (w_frame_end)
  );

  // Stage 0: address drive straight from the counters
  assign read_x = w_active ? w_h_cnt : '0;
  assign read_y = w_active ? w_v_cnt : '0;
  assign vblank = w_vblank;

  // Stage 1: timing flags wait here while the RAM returns read_palette
  logic r_vld_p1;
  logic r_hs_p1;
  logic r_vs_p1;

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_hs_p1  <= 1'b1;
      r_vs_p1  <= 1'b1;
    end else begin
      r_vld_p1 <= w_active;
      r_hs_p1  <= w_hs_raw;
      r_vs_p1  <= w_vs_raw;
    end
  end

  // Stage 2: output registers, sync/de aligned with rgb
  logic r_de_p2;
  logic r_hs_p2;
  logic r_vs_p2;
  rgb_t r_rgb_p2;

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      r_de_p2  <= 1'b0;
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= 1'b1;
      r_rgb_p2 <= '0;
    end else begin
      r_de_p2  <= r_vld_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_rgb_p2 <= pal_to_rgb(read_palette, r_vld_p1);
    end
  end

  assign de    = r_de_p2;
  assign hsync = r_hs_p2;
  assign vsync = r_vs_p2;
  assign rgb   = r_rgb_p2;

  // Swap FSM: a request is held until the frame-end cycle so no torn frame is shown
  swap_state_t r_state;
  logic        r_front_buf;
  logic        r_swap_done;

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      r_state     <= SWAP_IDLE;
      r_front_buf <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      if (w_frame_end && ((r_state == SWAP_PENDING) || swap_req)) begin
        r_front_buf <= ~r_front_buf;
        r_swap_done <= 1'b1;
        r_state     <= SWAP_IDLE;
      end else if (swap_req) begin
        r_state <= SWAP_PENDING;
      end
    end
  end

  assign front_buf = r_front_buf;
  assign read_buf  = r_front_buf;
  assign swap_done = r_swap_done;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout on a shrunk raster: table spot checks, randomized swaps
// against a raster-position model, and hand sequences for swap and reset corner cases.
module tb_frame_scanout;

  localparam int HA = 16, HFP = 4, HS = 3, HBP = 3;
  localparam int VA = 6,  VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;  // 26
  localparam int VT = VA + VFP + VS + VBP;  // 12
  localparam int FRAME = HT * VT;           // 312

  logic        clk_33m = 1'b0;
  logic        rst = 1'b1;
  logic        swap_req = 1'b0;
  logic [1:0]  read_palette;
  logic [10:0] read_x, read_y;
  logic        read_buf, swap_done, front_buf, vblank, hsync, vsync, de;
  logic [23:0] rgb;

  frame_scanout #(
    .COOR_WIDTH(11), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk_33m(clk_33m), .rst(rst), .read_x(read_x), .read_y(read_y),
    .read_buf(read_buf), .read_palette(read_palette), .swap_req(swap_req),
    .swap_done(swap_done), .front_buf(front_buf), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
  );

  always #15 clk_33m = ~clk_33m;

  // Frame RAM model: pixel value is the low two bits of the column, one cycle late
  logic [1:0] r_ram_q = 2'd0;
  always @(posedge clk_33m) r_ram_q <= read_x[1:0];
  assign read_palette = r_ram_q;

  logic [23:0] PAL [4] = '{24'hF7F7F7, 24'hACACAC, 24'h535353, 24'h000000};

  int n_checks = 0;
  int n_errs   = 0;
  int k        = 0;     // clock edges since reset released = raster position index
  int sw_cnt   = 0;
  bit req_f [64];       // frame index (since reset) that saw at least one swap request

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  function automatic bit exp_fb(input int kk);
    bit p = 1'b0;
    for (int f = 0; f < kk / FRAME && f < 64; f++) p ^= req_f[f];
    return p;
  endfunction

  function automatic bit exp_sd(input int kk);
    if (kk == 0 || (kk % FRAME) != 0 || (kk / FRAME) > 64) return 1'b0;
    return req_f[kk / FRAME - 1];
  endfunction

  task automatic check_all();
    int h, v, hp, vp;
    bit a, ap;
    logic e_de, e_hs, e_vs;
    logic [23:0] e_rgb;
    h = k % HT;
    v = (k / HT) % VT;
    a = (h < HA) && (v < VA);
    chk("read_x", 32'(read_x), a ? 32'(h) : 32'd0);
    chk("read_y", 32'(read_y), a ? 32'(v) : 32'd0);
    chk("vblank", 32'(vblank), 32'(v >= VA));
    e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 24'h0;
    if (k >= 2) begin
      hp = (k - 2) % HT;
      vp = ((k - 2) / HT) % VT;
      ap = (hp < HA) && (vp < VA);
      e_de = ap;
      e_hs = !(hp >= HA + HFP && hp < HA + HFP + HS);
      e_vs = !(vp >= VA + VFP && vp < VA + VFP + VS);
      e_rgb = ap ? PAL[hp % 4] : 24'h0;
    end
    chk("de", 32'(de), 32'(e_de));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("rgb", 32'(rgb), 32'(e_rgb));
    chk("front_buf", 32'(front_buf), 32'(exp_fb(k)));
    chk("read_buf", 32'(read_buf), 32'(exp_fb(k)));
    chk("swap_done", 32'(swap_done), 32'(exp_sd(k)));
  endtask

  task automatic tick(input logic r, input logic s);
    rst = r;
    swap_req = s;
    @(posedge clk_33m);
    if (r) begin
      k = 0;
      for (int f = 0; f < 64; f++) req_f[f] = 1'b0;
    end else begin
      if (s && (k / FRAME) < 64) req_f[k / FRAME] = 1'b1;
      k++;
    end
    #1;
    if (swap_done) sw_cnt++;
    check_all();
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (k != target) begin
      if (guard > 5000) begin
        n_checks++;
        n_errs++;
        $display("FAIL run_to: stuck at k=%0d, wanted %0d", k, target);
        return;
      end
      tick(1'b0, 1'b0);
      guard++;
    end
  endtask

  typedef struct {
    int          k;
    logic [10:0] rx, ry;
    logic        vbl, de, hs, vs;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int F, G, H, R;
    tbl[0]  = '{0,   11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[1]  = '{2,   11'd2, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hF7F7F7};
    tbl[2]  = '{3,   11'd3, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hACACAC};
    tbl[3]  = '{4,   11'd4, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h535353};
    tbl[4]  = '{5,   11'd5, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000};
    tbl[5]  = '{17,  11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000};
    tbl[6]  = '{18,  11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[7]  = '{22,  11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[8]  = '{24,  11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[9]  = '{25,  11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[10] = '{28,  11'd2, 11'd1, 1'b0, 1'b1, 1'b1, 1'b1, 24'hF7F7F7};
    tbl[11] = '{106, 11'd2, 11'd4, 1'b0, 1'b1, 1'b1, 1'b1, 24'hF7F7F7};
    tbl[12] = '{156, 11'd0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[13] = '{210, 11'd0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[14] = '{262, 11'd0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[15] = '{312, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[16] = '{314, 11'd2, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hF7F7F7};

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);

    // Free run from reset against hand-derived raster points
    for (int i = 0; i < 17; i++) begin
      run_to(tbl[i].k);
      chk("tbl_rx", 32'(read_x), 32'(tbl[i].rx));
      chk("tbl_ry", 32'(read_y), 32'(tbl[i].ry));
      chk("tbl_vblank", 32'(vblank), 32'(tbl[i].vbl));
      chk("tbl_de", 32'(de), 32'(tbl[i].de));
      chk("tbl_hsync", 32'(hsync), 32'(tbl[i].hs));
      chk("tbl_vsync", 32'(vsync), 32'(tbl[i].vs));
      chk("tbl_rgb", 32'(rgb), 32'(tbl[i].rgb));
    end

    // Random swap requests over two more frames
    while (k < 3 * FRAME) tick(1'b0, $urandom_range(0, 199) == 0);

    // Mid-frame request: held until the frame-end cycle
    F = k / FRAME + 1;
    run_to(F * FRAME + 100);
    tick(1'b0, 1'b1);
    run_to((F + 1) * FRAME - 1);
    chk("mid_fb_held", 32'(front_buf), 32'(exp_fb(F * FRAME)));
    chk("mid_no_done", 32'(swap_done), 32'd0);
    tick(1'b0, 1'b0);
    chk("mid_fb_toggled", 32'(front_buf), 32'(!exp_fb(F * FRAME)));
    chk("mid_done", 32'(swap_done), 32'd1);
    chk("mid_read_buf", 32'(read_buf), 32'(!exp_fb(F * FRAME)));
    chk("mid_addr00", 32'({read_x, read_y}), 32'd0);
    tick(1'b0, 1'b0);
    chk("mid_done_1cyc", 32'(swap_done), 32'd0);

    // Request exactly on the frame-end cycle
    G = k / FRAME + 1;
    run_to(G * FRAME - 1);
    tick(1'b0, 1'b1);
    chk("fe_done", 32'(swap_done), 32'd1);
    chk("fe_fb", 32'(front_buf), 32'(!exp_fb(G * FRAME - 1)));

    // Three requests in one frame give one toggle
    H = G + 1;
    run_to(H * FRAME);
    sw_cnt = 0;
    run_to(H * FRAME + 10);  tick(1'b0, 1'b1);
    run_to(H * FRAME + 60);  tick(1'b0, 1'b1);
    run_to(H * FRAME + 260); tick(1'b0, 1'b1);
    run_to((H + 1) * FRAME + 2);
    chk("triple_done_cnt", 32'(sw_cnt), 32'd1);
    chk("triple_fb", 32'(front_buf), 32'(!exp_fb(H * FRAME)));

    // Reset mid-frame with a swap pending and front_buf=1
    R = k / FRAME + 1;
    if (!exp_fb(k)) begin
      run_to(R * FRAME + 5);
      tick(1'b0, 1'b1);
      R++;
    end
    run_to(R * FRAME + 5);
    tick(1'b0, 1'b1);
    run_to(R * FRAME + 3 * HT + 8);
    chk("pre_rst_fb", 32'(front_buf), 32'd1);
    tick(1'b1, 1'b0);
    chk("rst_addr", 32'({read_x, read_y}), 32'd0);
    chk("rst_fb", 32'(front_buf), 32'd0);
    chk("rst_sync", 32'({hsync, vsync, de}), 32'b110);
    chk("rst_rgb", 32'(rgb), 32'd0);
    tick(1'b1, 1'b1);
    sw_cnt = 0;
    run_to(FRAME + 3);
    chk("rst_no_done", 32'(sw_cnt), 32'd0);
    chk("rst_fb_after", 32'(front_buf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/frame_scanout.md
# frame_scanout

Display-side reader of the double-buffered frame RAM filled by the sprite painter. It generates 800×480 LCD timing at 33 MHz and issues read addresses to the front buffer. Each 2-bit palette index is expanded to RGB888 and driven with hsync/vsync/de. Buffer swaps requested by the renderer take effect only on a frame boundary, so a partially painted frame is never shown.

## Interface
Parameters:
- COOR_WIDTH, 11, width of all coordinate counters/ports
- H_ACTIVE, 800, visible pixels per line
- H_FP, 210, horizontal front porch (pixels)
- H_SYNC, 20, hsync pulse width
- H_BP, 26, horizontal back porch (H_TOTAL = 1056)
- V_ACTIVE, 480, visible lines
- V_FP, 22, vertical front porch (lines)
- V_SYNC, 10, vsync pulse width
- V_BP, 13, vertical back porch (V_TOTAL = 525)

Ports:
- clk_33m  in  1  pixel clock
- rst  in  1  reset: synchronous, active-high
- read_x  out  COOR_WIDTH  frame RAM read column
- read_y  out  COOR_WIDTH  frame RAM read row
- read_buf  out  1  buffer being read (= front_buf)
- read_palette  in  2  RAM data, valid 1 cycle after address
- swap_req  in  1  one-cycle pulse: back buffer complete
- swap_done  out  1  one-cycle pulse: swap taken
- front_buf  out  1  buffer currently displayed
- vblank  out  1  high while v_cnt >= V_ACTIVE (undelayed)
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  data enable, high on visible pixels
- rgb  out  24  pixel colour, {R,G,B}

## Operation
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 and wraps.
- Segment order per line: active [0,H_ACTIVE), front porch, sync, back porch. The vertical axis uses the same order.
- Stage 0 (counter cycle):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - read_x/read_y = h_cnt/v_cnt when active, else 0 (combinational from counters)
  - hs_raw = low when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_raw is decoded the same way on v_cnt.
- Stage 1: active, hs_raw and vs_raw are registered; read_palette arrives.
- Stage 2 (output registers):
  - de, hsync and vsync take the stage-1 values.
  - rgb = palette colour when stage-1 active, else 0.
- Palette (package constants): 0→F7F7F7, 1→ACACAC, 2→535353, 3→000000.
- Swap FSM, states IDLE and PENDING:
  - swap_req moves the FSM to PENDING.
  - Frame-end cycle = h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.
  - At frame end in PENDING, or at frame end with swap_req high: front_buf toggles, swap_done pulses that cycle, FSM returns to IDLE.
  - swap_req while PENDING is absorbed; at most one toggle per frame.
- Counter arithmetic is unsigned COOR_WIDTH bits. Parameters must satisfy H_TOTAL, V_TOTAL < 2^COOR_WIDTH; check with an elaboration-time assertion.

## Timing
- Reset values:
  - h_cnt=0, v_cnt=0, front_buf=0, FSM=IDLE
  - all pipeline registers cleared
  - hsync=1, vsync=1, de=0, rgb=0, swap_done=0
  - read_x=0, read_y=0, vblank=0
- After rst deasserts, counters advance every cycle. The first pixel (0,0) appears on rgb/de 2 cycles after its address was driven.
- Fixed pipeline latency of 2 cycles from address to rgb. hsync/vsync/de carry the same 2-cycle delay, so they stay aligned with rgb.
- read_buf changes only at the frame-end → (0,0) transition. Address (0,0) of the next frame already uses the new buffer.
- rst asserted mid-frame: on the next edge, everything returns to reset values. A pending swap is discarded.
- swap_req in the same cycle as rst: ignored.

## Structure
- Package display_pkg:
  - H/V timing defaults
  - typedef logic [1:0] palette_t
  - typedef logic [23:0] rgb_t
  - PALETTE rgb_t array, 4 entries
  - shared with the sprite painter and frame RAM wrapper.
- Sub-module video_timing: h/v counters, active, sync and vblank decode, frame-end strobe.
- frame_scanout contains the address drive, 2-stage pipeline, palette map and swap FSM.
- Target is about 150–250 lines total.

## Test plan
- Reset then free-run 2 frames:
  - hsync low 20 cycles starting at h_cnt=1010 (+2 latency)
  - line period 1056 cycles
  - vsync low exactly 10 lines
  - frame period 554400 cycles
- RAM model returns read_x[1:0] with 1-cycle latency:
  - rgb sequence F7F7F7, ACACAC, 535353, 000000 repeating from the first de cycle
  - de high for exactly 800 cycles per line, 480 lines
- Mid-frame swap_req pulse:
  - front_buf unchanged until the frame-end cycle
  - then toggles 0→1 with a single swap_done pulse
  - next (0,0) read has read_buf=1
- swap_req exactly on the frame-end cycle: swap in that same cycle. Three swap_req pulses in one frame: exactly one toggle.
- rst asserted at h_cnt=400, v_cnt=200 with PENDING set:
  - next cycle counters=0, front_buf=0, hsync=vsync=1, de=0
  - no swap_done at the following frame end
- Blanking region: read_x=read_y=0, rgb=0 and vblank=1 for all v_cnt ≥ 480.
